// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port A arbiter: FSM states and the request bundle.
package dmem_arb_pkg;

    localparam int DMEM_AW = 30;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [3:0]         we;
        logic [DMEM_AW-1:0] addr;
        logic [31:0]        wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// Saturating up-counter with synchronous clear; holds at LIMIT.
module dmem_arb_sat_ctr #(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU / debug arbiter for DataRam port A. Define DMEM_ARB_STATS_EN to build the
// conflict and forced-grant statistics counters; otherwise they read 0.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic [3:0]    dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [3:0]    ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [31:0]   ram_dina,
    input  logic [31:0]   ram_douta,
    output logic [31:0]   ram_rdata,
    output logic [31:0]   stat_conflict,
    output logic [15:0]   stat_forced
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_state_e    state, state_next;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          wait_full, lock_full;
    dmem_req_t     cpu_r, dbg_r, sel;

    assign wait_full = (wait_cnt == WW'(MAX_WAIT));
    assign lock_full = (lock_cnt == LW'(LOCK_MAX));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ARB;
        else
            state <= state_next;
    end

    // Grants are decided in the request cycle; reset masks both so nothing reaches the RAM.
    always_comb begin
        state_next = state;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        if (!rst) begin
            case (state)
                ARB: begin
                    dbg_gnt = dbg_req & (~cpu_req | wait_full);
                    cpu_gnt = cpu_req & ~dbg_gnt;
                    if (dbg_gnt && dbg_lock)
                        state_next = LOCK;
                end
                LOCK: begin
                    dbg_gnt = dbg_req & ~(cpu_req & lock_full);
                    cpu_gnt = cpu_req & ~dbg_gnt;
                    if (!dbg_lock || !dbg_req || cpu_gnt)
                        state_next = ARB;
                end
                default: state_next = ARB;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    dmem_arb_sat_ctr #(.W(WW), .LIMIT(WW'(MAX_WAIT))) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .clr (dbg_gnt | ~dbg_req),
        .inc (dbg_req & ~dbg_gnt),
        .cnt (wait_cnt)
    );

    // The grant that enters LOCK counts toward the burst, so a full burst is LOCK_MAX grants.
    dmem_arb_sat_ctr #(.W(LW), .LIMIT(LW'(LOCK_MAX))) u_lock_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state_next == ARB),
        .inc (dbg_gnt & dbg_lock & cpu_req),
        .cnt (lock_cnt)
    );

    assign cpu_r = '{we: cpu_we, addr: DMEM_AW'(cpu_addr), wdata: cpu_wdata};
    assign dbg_r = '{we: dbg_we, addr: DMEM_AW'(dbg_addr), wdata: dbg_wdata};
    assign sel   = dbg_gnt ? dbg_r : cpu_r;

    assign ram_wea   = (cpu_gnt | dbg_gnt) ? sel.we : 4'b0000;
    assign ram_addra = sel.addr[AW-1:0];
    assign ram_dina  = sel.wdata;
    assign ram_rdata = ram_douta;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & (cpu_we == 4'b0000);
            dbg_rvalid <= dbg_gnt & (dbg_we == 4'b0000);
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic forced;
    // Only an ARB-state grant taken from a requesting CPU is a forced one.
    assign forced = (state == ARB) & dbg_gnt & cpu_req;

    dmem_arb_sat_ctr #(.W(32)) u_conflict_ctr (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (cpu_req & dbg_req),
        .cnt (stat_conflict)
    );

    dmem_arb_sat_ctr #(.W(16)) u_forced_ctr (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (forced),
        .cnt (stat_forced)
    );
`else
    assign stat_conflict = 32'd0;
    assign stat_forced   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural sync-read DataRam on port A.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, dbg_req = 1'b0, dbg_lock = 1'b0;
    logic [3:0]    cpu_we = '0, dbg_we = '0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [31:0]   cpu_wdata = '0, dbg_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [3:0]    ram_wea;
    logic [AW-1:0] ram_addra;
    logic [31:0]   ram_dina, ram_douta, ram_rdata, stat_conflict;
    logic [15:0]   stat_forced;

    logic [31:0]   mem [16];
    logic          preload = 1'b1;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(ram_douta), .ram_rdata(ram_rdata),
        .stat_conflict(stat_conflict), .stat_forced(stat_forced)
    );

    // DataRam port A model: byte-enable write and 1-cycle read at the same edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) mem[ram_addra[3:0]][b*8 +: 8] <= ram_dina[b*8 +: 8];
        end
        ram_douta <= mem[ram_addra[3:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_req = 0; dbg_req = 0; dbg_lock = 0; cpu_we = 0; dbg_we = 0;
        rst = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        cpu_req = 1; cpu_we = 4'hF; cpu_addr = 7; dbg_req = 1; dbg_we = 4'hF;
        step(); step(); step();
        preload = 0;
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got %b exp 0", cpu_gnt); end
        checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt got %b exp 0", dbg_gnt); end
        checks++; if (ram_wea !== 4'h0) begin errors++; $display("FAIL rst_ram_wea got %h exp 0", ram_wea); end
        checks++; if (ram_addra !== 30'd7) begin errors++; $display("FAIL rst_ram_addra got %0d exp 7", ram_addra); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_cpu_stall got %b exp 1", cpu_stall); end
        checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {cpu_rvalid, dbg_rvalid}); end
        checks++; if (stat_conflict !== 32'd0 || stat_forced !== 16'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d exp 0/0", stat_conflict, stat_forced); end
        cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
        rst = 0;
        step();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 5;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_gnt got %b/%b exp 1/0", cpu_gnt, cpu_stall); end
        checks++; if (ram_addra !== 30'd5 || ram_wea !== 4'h0) begin errors++; $display("FAIL cpu_rd_ram got %0d/%h exp 5/0", ram_addra, ram_wea); end
        step();
        cpu_req = 0;
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_rvalid got %b/%b exp 1/0", cpu_rvalid, dbg_rvalid); end
        checks++; if (ram_rdata !== 32'h1000_0005) begin errors++; $display("FAIL cpu_rd_data got %h exp 10000005", ram_rdata); end
        step();
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_rvalid_drop got %b exp 0", cpu_rvalid); end
    endtask

    task automatic test_dbg_write();
        dbg_req = 1; dbg_we = 4'b0011; dbg_addr = 9; dbg_wdata = 32'hAABB_CCDD;
        #1;
        checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL dbg_wr_gnt got %b/%b exp 1/0", dbg_gnt, cpu_gnt); end
        checks++; if (ram_wea !== 4'b0011 || ram_addra !== 30'd9 || ram_dina !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL dbg_wr_ram got %h/%0d/%h exp 3/9/aabbccdd", ram_wea, ram_addra, ram_dina); end
        step();
        dbg_req = 0; dbg_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9;
        #1;
        checks++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL dbg_wr_rvalid got %b/%b exp 0/0", dbg_rvalid, cpu_rvalid); end
        step();
        cpu_req = 0;
        #1;
        checks++; if (ram_rdata !== 32'h1000_CCDD || cpu_rvalid !== 1'b1) begin errors++; $display("FAIL dbg_wr_readback got %h/%b exp 1000ccdd/1", ram_rdata, cpu_rvalid); end
        step();
    endtask

    task automatic test_conflict();
        logic exp_d, prev_d;
        prev_d = 0;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 2;
        for (int c = 1; c <= 10; c++) begin
            exp_d = (c % 5 == 0);
            #1;
            checks++; if (dbg_gnt !== exp_d || cpu_gnt !== !exp_d || cpu_stall !== exp_d) begin
                errors++; $display("FAIL conflict_c%0d got dbg=%b cpu=%b stall=%b exp dbg=%b", c, dbg_gnt, cpu_gnt, cpu_stall, exp_d); end
            if (c > 1) begin
                checks++; if (cpu_rvalid !== !prev_d || dbg_rvalid !== prev_d) begin
                    errors++; $display("FAIL conflict_rvalid_c%0d got %b/%b exp %b/%b", c, cpu_rvalid, dbg_rvalid, !prev_d, prev_d); end
            end
            prev_d = exp_d;
            step();
        end
        cpu_req = 0; dbg_req = 0;
        #1;
        checks++; if (dbg_rvalid !== 1'b1 || ram_rdata !== 32'h1000_0002) begin errors++; $display("FAIL conflict_dbg_data got %b/%h exp 1/10000002", dbg_rvalid, ram_rdata); end
`ifdef DMEM_ARB_STATS_EN
        checks++; if (stat_conflict !== 32'd10 || stat_forced !== 16'd2) begin errors++; $display("FAIL stats got %0d/%0d exp 10/2", stat_conflict, stat_forced); end
`else
        checks++; if (stat_conflict !== 32'd0 || stat_forced !== 16'd0) begin errors++; $display("FAIL stats got %0d/%0d exp 0/0", stat_conflict, stat_forced); end
`endif
        step();
    endtask

    task automatic test_lock();
        logic exp_d;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 3;
        dbg_req = 1; dbg_we = 0; dbg_addr = 4; dbg_lock = 1;
        // 4 CPU, 8 locked debug, CPU released (wait restarts at 1), forced again on 17
        for (int c = 1; c <= 17; c++) begin
            exp_d = (c >= 5 && c <= 12) || (c == 17);
            #1;
            checks++; if (dbg_gnt !== exp_d || cpu_gnt !== !exp_d) begin
                errors++; $display("FAIL lock_c%0d got dbg=%b cpu=%b exp dbg=%b", c, dbg_gnt, cpu_gnt, exp_d); end
            step();
        end
        cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        step();
    endtask

    task automatic test_reset_mid();
        logic exp_d;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 6;
        dbg_req = 1; dbg_we = 4'hF; dbg_addr = 8;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL mid_first_gnt got %b exp 1", cpu_gnt); end
        step();
        rst = 1;
        #1;
        checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || ram_wea !== 4'h0) begin
            errors++; $display("FAIL mid_rst_gnt got %b/%b/%h exp 0/0/0", cpu_gnt, dbg_gnt, ram_wea); end
        step();
        rst = 0;
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b/%b exp 0/0", cpu_rvalid, dbg_rvalid); end
        // wait_cnt restarts from 0: four CPU grants before the forced debug write
        for (int c = 1; c <= 5; c++) begin
            exp_d = (c == 5);
            #1;
            checks++; if (dbg_gnt !== exp_d || cpu_gnt !== !exp_d) begin
                errors++; $display("FAIL mid_after_c%0d got dbg=%b cpu=%b exp dbg=%b", c, dbg_gnt, cpu_gnt, exp_d); end
            step();
        end
        cpu_req = 0; dbg_req = 0; dbg_we = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_conflict();
        test_lock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
